// File: rtl/otter_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// one iteration per clock, with start/busy/done handshake.
module otter_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic             neg_res, neg_rem, last_iter;
  logic [CNT_W-1:0] cnt;

  logic             accept, is_div, a_signed, b_signed, a_neg, b_neg;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  // Operand decode on the accepting edge: signedness, magnitudes and special cases.
  assign accept   = start && (state != CALC);
  assign is_div   = op[2];
  assign a_signed = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
  assign b_signed = is_div ? ~op[0] : (op[1:0] == 2'b01);
  assign a_neg    = a_signed && srcA[WIDTH-1];
  assign b_neg    = b_signed && srcB[WIDTH-1];
  assign a_mag    = a_neg ? -srcA : srcA;
  assign b_mag    = b_neg ? -srcB : srcB;
  assign div_zero = is_div && (srcB == '0);
  assign div_ovf  = is_div && !op[0] && (srcA == MOST_NEG) && (srcB == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? srcA : '1;
    else if (div_ovf)
      special_res = op[1] ? '0 : MOST_NEG;
  end

  // One iteration: multiply shifts {carry,hi,lo} right; divide shifts {hi,lo} left.
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    step_hi   = acc_hi;
    step_lo   = acc_lo;
    if (op_q[2]) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, final_res;

  always_comb begin
    prod_fix  = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_fix   = neg_res ? -acc_lo : acc_lo;
    rem_fix   = neg_rem ? -acc_hi : acc_hi;
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // CALC spends WIDTH iteration edges, then one edge applying sign correction.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = special ? DONE : CALC;
        else if (state == DONE)
          state_nxt = IDLE;
      end
      CALC:    if (last_iter) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      last_iter <= 1'b0;
      cnt       <= '0;
      result    <= '0;
    end else if (accept) begin
      op_q      <= op;
      cnt       <= '0;
      last_iter <= 1'b0;
      if (special) begin
        result <= special_res;
      end else begin
        acc_hi  <= '0;
        acc_lo  <= is_div ? a_mag : b_mag;
        opnd    <= is_div ? b_mag : a_mag;
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
      end
    end else if (state == CALC) begin
      if (!last_iter) begin
        acc_hi    <= step_hi;
        acc_lo    <= step_lo;
        cnt       <= cnt + 1'b1;
        last_iter <= (cnt == CNT_W'(WIDTH-1));
      end else begin
        result <= final_res;
      end
    end
  end

  assign busy  = (state == CALC);
  assign ready = (state != CALC);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_otter_muldiv_unit.sv
// Self-checking bench for otter_muldiv_unit: directed and random ops against a
// plain-arithmetic reference model, plus latency, hold, ignore-start and reset checks.
module tb_otter_muldiv_unit;

  localparam int W = 32;
  localparam logic [W-1:0] MN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] srcA = '0, srcB = '0;
  logic         ready, busy, done;
  logic [W-1:0] result;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] last_exp = '0;

  otter_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = '0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == MN && b == '1) return MN;
        return ia / ib;
      end
      3'd5: return (b == 0) ? '1 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MN && b == '1) return '0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    return o[2] && (b == 0 || (!o[0] && a == MN && b == '1));
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (or after timeout).
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int glitch);
    logic [W-1:0] exp;
    bit spec, got, seen_busy;
    int cyc;
    exp  = model(o, a, b);
    spec = is_special(o, a, b);
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); srcA = $urandom; srcB = $urandom;
    cyc = 0; got = 0; seen_busy = 0;
    while (cyc <= 100) begin
      if (busy) seen_busy = 1;
      if (done) begin got = 1; break; end
      if (cyc == 5 && !spec) checkOutput("hold_in_calc", result, last_exp);
      start = (cyc == glitch);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $error("[TB] FAIL timeout: op %0d observed no done, required done within 100 cycles", o);
    end else begin
      checkOutput($sformatf("latency_op%0d", o), cyc, spec ? 0 : W + 1);
      checkOutput($sformatf("result_op%0d_%h_%h", o, a, b), result, exp);
      checkOutput("busy_seen", seen_busy, !spec);
      checkOutput("ready_in_done", ready, 1'b1);
    end
    last_exp = exp;
  endtask

  task automatic idleAndCheckHold();
    repeat (3) @(negedge clk);
    checkOutput("hold_idle", result, last_exp);
    checkOutput("done_idle", done, 1'b0);
  endtask

  initial begin
    logic [2:0] ro;
    logic [W-1:0] ra, rb;

    @(negedge clk);
    checkOutput("reset_result", result, '0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", ready, 1'b1);

    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
    checkOutput("mul_7_m3", result, 32'hFFFF_FFEB);
    idleAndCheckHold();
    applyStimulus(3'd1, MN, MN, -1);
    idleAndCheckHold();
    applyStimulus(3'd3, '1, '1, -1);
    idleAndCheckHold();
    applyStimulus(3'd2, '1, '1, -1);
    idleAndCheckHold();
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
    applyStimulus(3'd5, 32'd100, 32'd7, -1);
    applyStimulus(3'd7, 32'd100, 32'd7, -1);
    idleAndCheckHold();

    applyStimulus(3'd4, 32'd5, 32'd0, -1);
    idleAndCheckHold();
    applyStimulus(3'd7, 32'd5, 32'd0, -1);
    applyStimulus(3'd4, MN, '1, -1);
    applyStimulus(3'd6, MN, '1, -1);
    idleAndCheckHold();

    // Ignored start mid-calculation, then back-to-back issue from DONE.
    applyStimulus(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);
    applyStimulus(3'd5, 32'hDEAD_BEEF, 32'd13, -1);
    idleAndCheckHold();

    // Asynchronous reset mid-operation.
    op = 3'd3; srcA = 32'hCAFE_F00D; srcB = 32'h0BAD_BEEF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_result", result, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_exp = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_stale_done", done, 1'b0);
    end
    applyStimulus(3'd3, 32'hCAFE_F00D, 32'h0BAD_BEEF, -1);
    idleAndCheckHold();

    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      applyStimulus(ro, ra, rb, -1);
      if ($urandom_range(0, 1) == 1) idleAndCheckHold();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
